// File: rtl/tdm_frame_collector.sv
// TDM frame collector: rebuilds NUM_CHN-sample frames from a strobed stream,
// flags sync/timeout faults and keeps a saturating fault count.
module tdm_frame_collector #(
  parameter int NUM_CHN = 4,
  parameter int DATA_W  = 16,
  parameter int MAX_GAP = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      din_valid_i,
  input  logic                      din_sync_i,
  input  logic [DATA_W-1:0]         din_i,
  output logic [NUM_CHN*DATA_W-1:0] frame_o,
  output logic                      frame_valid_o,
  output logic                      locked_o,
  output logic                      sync_err_o,
  output logic                      timeout_err_o,
  output logic [15:0]               err_cnt_o
);

  localparam int IDX_W = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1;
  localparam int GAP_W = $clog2(MAX_GAP + 1);
  localparam bit SINGLE = (NUM_CHN == 1);

  typedef enum logic {HUNT, COLLECT} state_t;

  state_t                    state;
  logic [IDX_W-1:0]          chn_idx;
  logic [GAP_W-1:0]          gap_cnt;
  logic [NUM_CHN*DATA_W-1:0] shadow;
  logic [NUM_CHN*DATA_W-1:0] frame_next;
  logic [IDX_W-1:0]          slot;
  logic                      mid_frame;
  logic                      last_slot;
  logic                      sync_fault;
  logic                      tmo_fault;

  assign mid_frame = (state == COLLECT) && (chn_idx != '0);
  assign last_slot = (chn_idx == IDX_W'(NUM_CHN - 1));

  // A sync sample always lands in slot 0, whatever state we are in.
  assign slot = din_sync_i ? '0 : chn_idx;

  always_comb begin
    frame_next = shadow;
    frame_next[slot*DATA_W +: DATA_W] = din_i;
  end

  assign sync_fault = din_valid_i && (state == COLLECT) &&
                      (din_sync_i ? (chn_idx != '0) : (chn_idx == '0));

  assign tmo_fault = !din_valid_i && mid_frame &&
                     (gap_cnt == GAP_W'(MAX_GAP - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= HUNT;
      chn_idx       <= '0;
      gap_cnt       <= '0;
      shadow        <= '0;
      frame_o       <= '0;
      frame_valid_o <= 1'b0;
      locked_o      <= 1'b0;
      sync_err_o    <= 1'b0;
      timeout_err_o <= 1'b0;
      err_cnt_o     <= '0;
    end else begin
      frame_valid_o <= 1'b0;
      sync_err_o    <= sync_fault;
      timeout_err_o <= tmo_fault;
      if ((sync_fault || tmo_fault) && (err_cnt_o != 16'hFFFF))
        err_cnt_o <= err_cnt_o + 16'd1;

      if (din_valid_i) begin
        gap_cnt <= '0;
        if (din_sync_i) begin
          shadow   <= frame_next;
          state    <= COLLECT;
          locked_o <= 1'b1;
          if (SINGLE) begin
            chn_idx       <= '0;
            frame_o       <= frame_next;
            frame_valid_o <= 1'b1;
          end else begin
            chn_idx <= IDX_W'(1);
          end
        end else if (state == COLLECT) begin
          if (chn_idx == '0) begin
            state    <= HUNT;
            locked_o <= 1'b0;
          end else begin
            shadow <= frame_next;
            if (last_slot) begin
              chn_idx       <= '0;
              frame_o       <= frame_next;
              frame_valid_o <= 1'b1;
            end else begin
              chn_idx <= chn_idx + IDX_W'(1);
            end
          end
        end
      end else if (mid_frame) begin
        if (tmo_fault) begin
          state    <= HUNT;
          locked_o <= 1'b0;
          chn_idx  <= '0;
          gap_cnt  <= '0;
        end else begin
          gap_cnt <= gap_cnt + GAP_W'(1);
        end
      end
    end
  end

endmodule
